// File: rtl/multicycle_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl_if
// Description : Handshake/control bundle between the multi-cycle controller
//               and the fetch/decode + datapath side of the RV32I lab core.
// Revision    : 1.0  initial release
// ============================================================================
interface multicycle_ctrl_if;
  // decode fields and datapath status, driven by the datapath side
  logic        run;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic        alu_zero;
  // controls issued by the controller
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        ir_write;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        alu_src_b;
  logic [3:0]  alu_ctrl;
  logic [1:0]  wb_sel;
  logic [2:0]  state;
  logic        trap;
  logic [31:0] instr_count;

  // datapath / fetch side
  modport master (
    output run, opcode, funct3, funct7, alu_zero,
    input  pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
           alu_src_b, alu_ctrl, wb_sel, state, trap, instr_count
  );

  // controller side
  modport slave (
    input  run, opcode, funct3, funct7, alu_zero,
    output pc_write, pc_src, ir_write, reg_write, mem_read, mem_write,
           alu_src_b, alu_ctrl, wb_sel, state, trap, instr_count
  );
endinterface
`default_nettype wire

// File: rtl/multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : multicycle_ctrl
// Description : Multi-cycle IF/ID/EX/MEM/WB control unit for the RV32I lab
//               core. Issues PC/IR/regfile/ALU/memory controls, counts
//               retired instructions and traps on unsupported encodings.
// Revision    : 1.0  initial release
// ============================================================================
module multicycle_ctrl (
  input  logic                clk,
  input  logic                rst,
  multicycle_ctrl_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_TRAP = 3'd5
  } state_t;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  state_t      state_q, state_d;
  logic [6:0]  opcode_q;
  logic [2:0]  funct3_q;
  logic [6:0]  funct7_q;
  logic [31:0] count_q;

  logic        id_legal;
  logic        retire;
  logic        alt_f7;
  logic        is_r, is_i, is_lw, is_sw, is_br, is_jal, is_lui;

  logic        pc_write, ir_write, reg_write, mem_read, mem_write, alu_src_b;
  logic [1:0]  pc_src, wb_sel;
  logic [3:0]  alu_ctrl;

  // Only legal encodings ever leave ID, so an exact match of the latched
  // funct7 against 0100000 is all SUB/SRA selection needs.
  assign alt_f7 = (funct7_q == F7_ALT);
  assign is_r   = (opcode_q == OP_R);
  assign is_i   = (opcode_q == OP_I);
  assign is_lw  = (opcode_q == OP_LW);
  assign is_sw  = (opcode_q == OP_SW);
  assign is_br  = (opcode_q == OP_BR);
  assign is_jal = (opcode_q == OP_JAL);
  assign is_lui = (opcode_q == OP_LUI);

  function automatic logic [3:0] alu_op(input logic [2:0] f3,
                                        input logic       sub_ok,
                                        input logic       alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = (sub_ok && alt) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  // Classify the live decode fields during ID to pick EX or TRAP.
  always_comb begin
    id_legal = 1'b0;
    case (bus.opcode)
      OP_R:   id_legal = (bus.funct7 == 7'b0000000) ||
                         ((bus.funct7 == F7_ALT) &&
                          ((bus.funct3 == 3'b000) || (bus.funct3 == 3'b101)));
      OP_I: begin
        case (bus.funct3)
          3'b001:  id_legal = (bus.funct7 == 7'b0000000);
          3'b101:  id_legal = (bus.funct7 == 7'b0000000) || (bus.funct7 == F7_ALT);
          default: id_legal = 1'b1;
        endcase
      end
      OP_LW:  id_legal = (bus.funct3 == 3'b010);
      OP_SW:  id_legal = (bus.funct3 == 3'b010);
      OP_BR:  id_legal = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);
      OP_JAL: id_legal = 1'b1;
      OP_LUI: id_legal = 1'b1;
      default: id_legal = 1'b0;
    endcase
  end

  // Next-state and control decode; reset masks every enable and the retire.
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    pc_write  = 1'b0;
    pc_src    = 2'd0;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    alu_src_b = 1'b0;
    alu_ctrl  = ALU_ADD;
    wb_sel    = 2'd0;

    case (state_q)
      S_IF: begin
        if (bus.run) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_ID;
        end
      end
      S_ID: begin
        state_d = id_legal ? S_EX : S_TRAP;
      end
      S_EX: begin
        if (is_r || is_i) begin
          alu_src_b = is_i;
          alu_ctrl  = alu_op(funct3_q, is_r, alt_f7);
          state_d   = S_WB;
        end else if (is_lw || is_sw) begin
          alu_src_b = 1'b1;
          alu_ctrl  = ALU_ADD;
          state_d   = S_MEM;
        end else if (is_br) begin
          alu_ctrl  = ALU_SUB;
          pc_src    = 2'd1;
          pc_write  = funct3_q[0] ? !bus.alu_zero : bus.alu_zero;
          retire    = 1'b1;
          state_d   = S_IF;
        end else if (is_jal) begin
          pc_write  = 1'b1;
          pc_src    = 2'd2;
          state_d   = S_WB;
        end else if (is_lui) begin
          alu_src_b = 1'b1;
          alu_ctrl  = ALU_PASS_B;
          state_d   = S_WB;
        end else begin
          state_d   = S_TRAP;
        end
      end
      S_MEM: begin
        if (is_lw) begin
          mem_read  = 1'b1;
          state_d   = S_WB;
        end else begin
          mem_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_IF;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        wb_sel    = is_lw ? 2'd1 : (is_jal ? 2'd2 : 2'd0);
        retire    = 1'b1;
        state_d   = S_IF;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IF;
      end
    endcase

    if (rst) begin
      pc_write  = 1'b0;
      ir_write  = 1'b0;
      reg_write = 1'b0;
      mem_read  = 1'b0;
      mem_write = 1'b0;
      retire    = 1'b0;
    end
  end

  // State, latched decode fields and retired-instruction counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IF;
      opcode_q <= 7'd0;
      funct3_q <= 3'd0;
      funct7_q <= 7'd0;
      count_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_ID) begin
        opcode_q <= bus.opcode;
        funct3_q <= bus.funct3;
        funct7_q <= bus.funct7;
      end
      if (retire) begin
        count_q <= count_q + 32'd1;
      end
    end
  end

  assign bus.pc_write    = pc_write;
  assign bus.pc_src      = pc_src;
  assign bus.ir_write    = ir_write;
  assign bus.reg_write   = reg_write;
  assign bus.mem_read    = mem_read;
  assign bus.mem_write   = mem_write;
  assign bus.alu_src_b   = alu_src_b;
  assign bus.alu_ctrl    = alu_ctrl;
  assign bus.wb_sel      = wb_sel;
  assign bus.state       = state_q;
  assign bus.trap        = (state_q == S_TRAP);
  assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_multicycle_ctrl
// Description : Self-checking bench for multicycle_ctrl. Directed scenarios
//               followed by random instruction streams, each checked against
//               a per-instruction expected-cycle model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_multicycle_ctrl;

  localparam int K_ILL = 0, K_R = 1, K_I = 2, K_LW = 3, K_SW = 4,
                 K_BR = 5, K_JAL = 6, K_LUI = 7;

  typedef struct packed {
    logic [2:0] st;
    logic       pcw;
    logic [1:0] pcs;
    logic       irw;
    logic       rw;
    logic       mr;
    logic       mw;
    logic       asb;
    logic [3:0] alu;
    logic [1:0] wbs;
    logic       trp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;

  multicycle_ctrl_if bus ();

  multicycle_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Instruction class straight from the supported-encoding rules.
  function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
    int k;
    k = K_ILL;
    case (op)
      7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5))) k = K_R;
      7'b0010011: if ((f3 != 3'd1 && f3 != 3'd5) || f7 == 7'h00 || (f3 == 3'd5 && f7 == 7'h20)) k = K_I;
      7'b0000011: if (f3 == 3'd2) k = K_LW;
      7'b0100011: if (f3 == 3'd2) k = K_SW;
      7'b1100011: if (f3 == 3'd0 || f3 == 3'd1) k = K_BR;
      7'b1101111: k = K_JAL;
      7'b0110111: k = K_LUI;
      default: k = K_ILL;
    endcase
    return k;
  endfunction

  function automatic logic [3:0] alu_expect(input int k, input logic [2:0] f3, input logic [6:0] f7);
    logic [3:0] tbl [8];
    logic [3:0] r;
    tbl = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    r = tbl[f3];
    if (f3 == 3'd0 && k == K_R && f7[5]) r = 4'd1;
    if (f3 == 3'd5 && f7[5]) r = 4'd7;
    return r;
  endfunction

  // Expected outputs of one cycle spent in state st for class k.
  function automatic exp_t mk(input int st, input int k, input logic [2:0] f3,
                              input logic [6:0] f7, input logic az);
    exp_t e;
    e = '0;
    e.st = st[2:0];
    case (st)
      0: begin e.irw = 1'b1; e.pcw = 1'b1; end
      2: begin
        case (k)
          K_R:   e.alu = alu_expect(k, f3, f7);
          K_I:   begin e.asb = 1'b1; e.alu = alu_expect(k, f3, f7); end
          K_LW, K_SW: e.asb = 1'b1;
          K_BR:  begin e.alu = 4'd1; e.pcs = 2'd1; e.pcw = (f3 == 3'd0) ? az : !az; end
          K_JAL: begin e.pcw = 1'b1; e.pcs = 2'd2; end
          K_LUI: begin e.asb = 1'b1; e.alu = 4'd10; end
          default: ;
        endcase
      end
      3: begin if (k == K_LW) e.mr = 1'b1; else e.mw = 1'b1; end
      4: begin
        e.rw  = 1'b1;
        e.wbs = (k == K_LW) ? 2'd1 : ((k == K_JAL) ? 2'd2 : 2'd0);
      end
      5: e.trp = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  // Drive one cycle of inputs, check outputs at the falling edge, advance.
  task automatic step(input exp_t e_in, input logic run_v, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7, input logic az,
                      input logic rst_v);
    exp_t e;
    e = e_in;
    rst = rst_v;
    bus.run = run_v;
    bus.opcode = op;
    bus.funct3 = f3;
    bus.funct7 = f7;
    bus.alu_zero = az;
    if (rst_v) begin
      e.pcw = 1'b0; e.irw = 1'b0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0;
    end
    @(negedge clk);
    chk("state",       32'(bus.state),     32'(e.st));
    chk("trap",        32'(bus.trap),      32'(e.trp));
    chk("instr_count", bus.instr_count,    model_cnt);
    chk("pc_write",    32'(bus.pc_write),  32'(e.pcw));
    chk("ir_write",    32'(bus.ir_write),  32'(e.irw));
    chk("reg_write",   32'(bus.reg_write), 32'(e.rw));
    chk("mem_read",    32'(bus.mem_read),  32'(e.mr));
    chk("mem_write",   32'(bus.mem_write), 32'(e.mw));
    if (!rst_v) begin
      chk("pc_src",    32'(bus.pc_src),    32'(e.pcs));
      chk("alu_src_b", 32'(bus.alu_src_b), 32'(e.asb));
      chk("alu_ctrl",  32'(bus.alu_ctrl),  32'(e.alu));
      chk("wb_sel",    32'(bus.wb_sel),    32'(e.wbs));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e = mk(0, K_ILL, 3'd0, 7'd0, 1'b0);
      e.irw = 1'b0;
      e.pcw = 1'b0;
      step(e, 1'b0, 7'($urandom), 3'($urandom), 7'($urandom), 1'($urandom), 1'b0);
    end
  endtask

  // Run one instruction from IF entry; rst_at selects a cycle index to reset in.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                           input logic az, input int rst_at);
    int   k;
    int   sts[$];
    logic run_v;
    logic rst_v;
    k = classify(op, f3, f7);
    sts.push_back(0);
    sts.push_back(1);
    case (k)
      K_ILL: ;
      K_BR:  sts.push_back(2);
      K_LW:  begin sts.push_back(2); sts.push_back(3); sts.push_back(4); end
      K_SW:  begin sts.push_back(2); sts.push_back(3); end
      default: begin sts.push_back(2); sts.push_back(4); end
    endcase
    for (int i = 0; i < sts.size(); i++) begin
      run_v = (i == 0) ? 1'b1 : 1'($urandom);
      rst_v = (i == rst_at);
      if (i == 1)
        step(mk(sts[i], k, f3, f7, az), run_v, op, f3, f7, az, rst_v);
      else
        step(mk(sts[i], k, f3, f7, az), run_v, 7'($urandom), 3'($urandom), 7'($urandom), az, rst_v);
      if (rst_v) begin
        model_cnt = 32'd0;
        return;
      end
    end
    if (k == K_ILL) begin
      for (int i = 0; i < 10; i++)
        step(mk(5, k, f3, f7, az), 1'b1, 7'($urandom), 3'($urandom), 7'($urandom), 1'($urandom), 1'b0);
      step(mk(5, k, f3, f7, az), 1'b1, 7'd0, 3'd0, 7'd0, 1'b0, 1'b1);
      model_cnt = 32'd0;
    end else begin
      model_cnt = model_cnt + 32'd1;
    end
  endtask

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    int         r;
    int         rst_at;

    rst = 1'b1;
    bus.run = 1'b0;
    bus.opcode = 7'd0;
    bus.funct3 = 3'd0;
    bus.funct7 = 7'd0;
    bus.alu_zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // reset state with run high: enables must stay low
    step(mk(0, K_ILL, 3'd0, 7'd0, 1'b0), 1'b1, 7'd0, 3'd0, 7'd0, 1'b0, 1'b1);

    // directed scenarios
    run_instr(7'b0110011, 3'd0, 7'b0100000, 1'b0, -1);   // SUB
    run_instr(7'b0000011, 3'd2, 7'd0,       1'b0, -1);   // LW
    run_instr(7'b0100011, 3'd2, 7'd0,       1'b0, -1);   // SW
    run_instr(7'b1100011, 3'd0, 7'd0,       1'b1, -1);   // BEQ taken
    run_instr(7'b1100011, 3'd1, 7'd0,       1'b1, -1);   // BNE not taken
    run_instr(7'b1101111, 3'd3, 7'h55,      1'b0, -1);   // JAL
    run_instr(7'b0010011, 3'd5, 7'b0100000, 1'b0, -1);   // SRAI
    run_instr(7'b0110111, 3'd7, 7'h7f,      1'b0, -1);   // LUI
    idle(5);
    run_instr(7'b1111111, 3'd0, 7'd0,       1'b0, -1);   // illegal -> TRAP, then reset
    run_instr(7'b1101111, 3'd0, 7'd0,       1'b0, 2);    // reset during JAL EX
    idle(1);
    run_instr(7'b0110011, 3'd6, 7'd0,       1'b0, 3);    // reset during R-ALU WB
    idle(1);
    run_instr(7'b0010011, 3'd1, 7'b0100000, 1'b0, -1);   // illegal SLLI variant

    // random instruction stream
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
      r  = int'($urandom_range(0, 9));
      f3 = 3'($urandom);
      f7 = ($urandom_range(0, 2) == 0) ? 7'($urandom) : (($urandom_range(0, 1) == 0) ? 7'h00 : 7'h20);
      case (r)
        0, 7:  op = 7'b0110011;
        1, 8:  op = 7'b0010011;
        2: begin op = 7'b0000011; if ($urandom_range(0, 3) != 0) f3 = 3'd2; end
        3: begin op = 7'b0100011; if ($urandom_range(0, 3) != 0) f3 = 3'd2; end
        4: begin op = 7'b1100011; if ($urandom_range(0, 3) != 0) f3 = 3'($urandom_range(0, 1)); end
        5:  op = 7'b1101111;
        6:  op = 7'b0110111;
        default: op = 7'($urandom);
      endcase
      rst_at = ($urandom_range(0, 15) == 0) ? int'($urandom_range(1, 3)) : -1;
      run_instr(op, f3, f7, 1'($urandom), rst_at);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
